// File: rtl/contadores_if.sv
// Divided-clock output bundle between the divider and its consumer.
`timescale 1ns/1ps

interface contadores_if;
   logic clk_out;

   modport master (output clk_out);
   modport slave  (input  clk_out);
endinterface

// File: rtl/contadores.sv
// Integer clock divider: clk_out has a period of DIVISOR clk_in cycles and is
// high for the first ceil(DIVISOR/2) cycles of each period.
`timescale 1ns/1ps

module contadores #(
   parameter int unsigned DIVISOR = 32'd4000,
   parameter int unsigned CW      = (DIVISOR < 32'd2) ? 32'd1 : $clog2(DIVISOR)
) (
   input  logic         clk_in,
   input  logic         rst,
   contadores_if.master div_if
);

   if ((DIVISOR < 32'd2) || (DIVISOR > 32'd16777216)) begin : g_bad_divisor
      $error("contadores: DIVISOR must lie in 2..2**24");
   end

   localparam logic [CW-1:0] LAST_CNT = CW'(DIVISOR - 32'd1);
   localparam logic [CW-1:0] HIGH_CNT = CW'((DIVISOR + 32'd1) / 32'd2);

   // Zero initialisers let the divider run correctly without ever seeing rst.
   logic [CW-1:0] cnt_q     = {CW{1'b0}};
   logic [CW-1:0] cnt_d;
   logic          clk_out_q = 1'b0;
   logic          clk_out_d;

   // Next-state: wrap at DIVISOR-1; output level follows the current count, so it lags cnt by one edge.
   always_comb begin
      cnt_d     = cnt_q;
      clk_out_d = clk_out_q;
      if (cnt_q == LAST_CNT) begin
         cnt_d = {CW{1'b0}};
      end else begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
      if (cnt_q < HIGH_CNT) begin
         clk_out_d = 1'b1;
      end else begin
         clk_out_d = 1'b0;
      end
   end

   // State registers with synchronous reset that aborts the running period.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt_q     <= {CW{1'b0}};
         clk_out_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
      end
   end

   assign div_if.clk_out = clk_out_q;

endmodule

// File: tb/tb_contadores.sv
// Directed bench for contadores: four instances (DIVISOR 8, 7, 2 and default)
// checked against hand-computed waveforms.
`timescale 1ns/1ps

module tb_contadores;

   localparam int CLK_HALF = 125;

   logic clk;
   logic rst8, rst7, rst2, rst_def;
   bit   done8, done7, done2, done_def;
   int   n_checks;
   int   n_fail;

   contadores_if if8 ();
   contadores_if if7 ();
   contadores_if if2 ();
   contadores_if if_def ();

   contadores #(.DIVISOR(8)) u_d8  (.clk_in(clk), .rst(rst8),    .div_if(if8));
   contadores #(.DIVISOR(7)) u_d7  (.clk_in(clk), .rst(rst7),    .div_if(if7));
   contadores #(.DIVISOR(2)) u_d2  (.clk_in(clk), .rst(rst2),    .div_if(if2));
   contadores                u_def (.clk_in(clk), .rst(rst_def), .div_if(if_def));

   initial begin
      clk = 1'b0;
      forever #CLK_HALF clk = ~clk;
   end

   task automatic chk_eq(input string tag, input int observed, input int expected);
      n_checks++;
      if (observed != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // DIVISOR=8: reset hold, release, and mid-period reset in both phases.
   initial begin : p_d8
      logic [15:0] pat16;
      logic [7:0]  pat8;
      pat16 = 16'h0F0F;
      pat8  = 8'h0F;
      rst8  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_eq("d8_in_reset", int'(if8.clk_out), 0);
      end
      rst8 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk_eq("d8_after_release", int'(if8.clk_out), int'(pat16[k]));
      end
      repeat (5) @(negedge clk);
      chk_eq("d8_cnt5_level", int'(if8.clk_out), 0);
      rst8 = 1'b1;
      @(negedge clk);
      chk_eq("d8_rst_low_phase", int'(if8.clk_out), 0);
      rst8 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk_eq("d8_restart_a", int'(if8.clk_out), int'(pat8[k]));
      end
      repeat (2) @(negedge clk);
      chk_eq("d8_cnt2_level", int'(if8.clk_out), 1);
      rst8 = 1'b1;
      @(negedge clk);
      chk_eq("d8_rst_high_phase", int'(if8.clk_out), 0);
      rst8 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk_eq("d8_restart_b", int'(if8.clk_out), int'(pat8[k]));
      end
      done8 = 1'b1;
   end

   // DIVISOR=2: toggles every clk_in cycle after release.
   initial begin : p_d2
      logic [7:0] pat;
      pat  = 8'h55;
      rst2 = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk_eq("d2_in_reset", int'(if2.clk_out), 0);
      end
      rst2 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk_eq("d2_toggle", int'(if2.clk_out), int'(pat[k]));
      end
      done2 = 1'b1;
   end

   // DIVISOR=7 free-run from power-up, with an rst pulse that never spans an edge.
   initial begin : p_d7
      int last_rise, high, tot_high, nrise;
      bit prev, cur;
      last_rise = -1;
      high      = 0;
      tot_high  = 0;
      nrise     = 0;
      prev      = 1'b0;
      rst7      = 1'b0;
      for (int cyc = 1; cyc <= 71; cyc++) begin
         @(negedge clk);
         cur = if7.clk_out;
         if (cur && !prev) begin
            if (last_rise >= 0) begin
               chk_eq("d7_period", cyc - last_rise, 7);
               chk_eq("d7_high", high, 4);
               chk_eq("d7_low", cyc - last_rise - high, 3);
            end
            last_rise = cyc;
            high      = 0;
            nrise++;
         end
         if (cur) begin
            high++;
            if (cyc <= 70) tot_high++;
         end
         prev = cur;
         if (cyc == 30) begin
            #10 rst7 = 1'b1;
            #20 rst7 = 1'b0;
         end
      end
      chk_eq("d7_rises", nrise, 11);
      chk_eq("d7_total_high", tot_high, 40);
      done7 = 1'b1;
   end

   // Default DIVISOR=4000, never reset: 1 ms period, 500 us each phase.
   initial begin : p_def
      longint t, t_rise, t_fall;
      bit     prev, cur, have_rise;
      int     nper;
      rst_def   = 1'b0;
      prev      = 1'b0;
      have_rise = 1'b0;
      nper      = 0;
      t_rise    = 0;
      t_fall    = 0;
      for (int cyc = 1; cyc <= 12010; cyc++) begin
         @(negedge clk);
         cur = if_def.clk_out;
         t   = $time;
         if (cur && !prev) begin
            if (have_rise) begin
               chk_eq("def_period_ns", int'(t - t_rise), 1000000);
               chk_eq("def_low_ns", int'(t - t_fall), 500000);
               nper++;
            end
            t_rise    = t;
            have_rise = 1'b1;
         end
         if (!cur && prev) begin
            chk_eq("def_high_ns", int'(t - t_rise), 500000);
            t_fall = t;
         end
         prev = cur;
      end
      chk_eq("def_periods", nper, 3);
      done_def = 1'b1;
   end

   initial begin : p_watchdog
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, done8=%0d done7=%0d done2=%0d done_def=%0d",
               done8, done7, done2, done_def);
      $fatal(1, "timeout");
   end

   initial begin : p_end
      n_checks = 0;
      n_fail   = 0;
      wait (done8 && done7 && done2 && done_def);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/contadores.md
CONTADORES -- requirements
Module: contadores

Interface
REQ-001 Parameter DIVISOR, default 4000, meaning the clk_in cycles per clk_out period; legal range 2..2^24.
REQ-002 Parameter CW, default derived as ceil(log2(DIVISOR)), meaning the internal counter width; no override needed.
REQ-003 clk_in  input  1  the single clock, 4 MHz nominal (250 ns period); all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 clk_out  output  1  divided clock output, driven directly from a flip-flop.

Function
REQ-006 The block SHALL contain one CW-bit up-counter cnt that counts 0..DIVISOR-1 on clk_in and wraps to 0 after DIVISOR-1.
REQ-007 Define HIGH_CNT = ceil(DIVISOR/2) and LOW_CNT = floor(DIVISOR/2).
REQ-008 clk_out SHALL be 1 while cnt is in 0..HIGH_CNT-1 and 0 while cnt is in HIGH_CNT..DIVISOR-1, as a registered output.
REQ-009 Even DIVISOR SHALL give exactly 50% duty; odd DIVISOR SHALL give high for (DIVISOR+1)/2 cycles and low for (DIVISOR-1)/2 cycles.
REQ-010 Output period SHALL be exactly DIVISOR clk_in cycles with no drift or skipped cycles across wraps.
REQ-011 clk_out SHALL change only one clk_in cycle after a rising edge (register-to-output), never combinationally from cnt.
REQ-012 DIVISOR = 2 SHALL produce clk_out toggling every clk_in cycle (clk_in/2).
REQ-013 With DIVISOR < 2, elaboration SHALL fail with a clear error.
REQ-014 The counter SHALL never hold a value >= DIVISOR; comparisons SHALL use the full CW width, with no truncation.
REQ-015 Default build: 4 MHz / 4000 = 1 kHz clk_out, high 2000 cycles, low 2000 cycles.

Reset
REQ-016 When rst=1 at a rising clk_in edge, cnt SHALL become 0 and clk_out SHALL become 0 on that edge.
REQ-017 On the first edge with rst=0 after reset, cnt SHALL become 1 and clk_out SHALL become 1, starting a fresh high phase.
REQ-018 Reset asserted mid-period (either phase) SHALL abort the period immediately at the next edge; no partial phase is completed.
REQ-019 All registers SHALL carry power-up initial value 0, so the block divides correctly even when rst is held 0 from time zero.
REQ-020 rst SHALL have no asynchronous effect; a pulse between edges SHALL be ignored.

Verification
REQ-021 DIVISOR=8, rst high 3 cycles then low -> clk_out 0 during reset, then 1 for 4 cycles, 0 for 4 cycles, repeating.
REQ-022 DIVISOR=7, free-run 10 periods -> each period 70 cycles total over 10 periods (7 each), high 4 and low 3 every period.
REQ-023 DIVISOR=2 -> clk_out toggles every clk_in cycle after reset release.
REQ-024 DIVISOR=8, rst pulsed for 1 cycle at cnt=5 -> clk_out 0 on that edge, then a full 4-high/4-low sequence restarts.
REQ-025 Default DIVISOR=4000, 250 ns clk_in, no reset ever asserted -> clk_out period 1.000 ms, 500 us high/500 us low, measured over 3 periods.
REQ-026 rst pulse entirely between clk_in edges -> no change to clk_out or the period.
